// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter, registers the fetched word into IF/ID,
// and applies reset / redirect / stall in strict priority. Also keeps fetch and flush counters.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_ir,
    output logic [6:0]  if_id_opcode,
    output logic        if_id_ir30,
    output logic        if_id_valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        ActReset,
        ActRedirect,
        ActStall,
        ActFetch
    } action_e;

    action_e     action;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] id_pc_q,     id_pc_d;
    logic [31:0] id_pc4_q,    id_pc4_d;
    logic [31:0] id_ir_q,     id_ir_d;
    logic        id_valid_q,  id_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        if (rst) begin
            action = ActReset;
        end else if (redirect) begin
            action = ActRedirect;
        end else if (stall) begin
            action = ActStall;
        end else begin
            action = ActFetch;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        id_ir_d     = id_ir_q;
        id_valid_d  = id_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (action)
            ActReset: begin
                pc_d        = PC_RESET;
                id_pc_d     = '0;
                id_pc4_d    = '0;
                id_ir_d     = NOP_INSN;
                id_valid_d  = 1'b0;
                fetch_cnt_d = '0;
                flush_cnt_d = '0;
            end
            ActRedirect: begin
                // Word-align the target; the word fetched this cycle is dropped as a bubble.
                pc_d        = {redirect_pc[31:2], 2'b00};
                id_pc_d     = '0;
                id_pc4_d    = '0;
                id_ir_d     = NOP_INSN;
                id_valid_d  = 1'b0;
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
            ActStall: begin
            end
            ActFetch: begin
                pc_d        = pc_plus4;
                id_pc_d     = pc_q;
                id_pc4_d    = pc_plus4;
                id_ir_d     = imem_data;
                id_valid_d  = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        pc_q        <= pc_d;
        id_pc_q     <= id_pc_d;
        id_pc4_q    <= id_pc4_d;
        id_ir_q     <= id_ir_d;
        id_valid_q  <= id_valid_d;
        fetch_cnt_q <= fetch_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    // All outputs come straight from registers: no path from stall/redirect.
    assign imem_addr    = pc_q;
    assign if_id_pc     = id_pc_q;
    assign if_id_pc4    = id_pc4_q;
    assign if_id_ir     = id_ir_q;
    assign if_id_opcode = id_ir_q[6:0];
    assign if_id_ir30   = id_ir_q[30];
    assign if_id_valid  = id_valid_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, redirect priority,
// reset during stall and PC wraparound, against hand-computed values.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_ir;
    logic [6:0]  if_id_opcode;
    logic        if_id_ir30;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    int n_checks;
    int n_fail;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_ir     (if_id_ir),
        .if_id_opcode (if_id_opcode),
        .if_id_ir30   (if_id_ir30),
        .if_id_valid  (if_id_valid),
        .fetch_cnt    (fetch_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents, used both to drive the DUT and to form expectations.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h00A0_0093;
        if (a == 32'h0000_3100) return 32'h40B5_0533;
        return {a[24:0], 7'h13};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                              input logic valid);
        check_eq({tag, ".pc"},    if_id_pc, pc);
        check_eq({tag, ".pc4"},   if_id_pc4, (valid ? pc + 32'd4 : 32'd0));
        check_eq({tag, ".ir"},    if_id_ir, ir);
        check_eq({tag, ".op"},    {25'd0, if_id_opcode}, {25'd0, ir[6:0]});
        check_eq({tag, ".ir30"},  {31'd0, if_id_ir30}, {31'd0, ir[30]});
        check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        @(negedge clk);
        step();

        // Reset state
        check_eq("rst.addr", imem_addr, 32'h3000);
        check_ifid("rst", 32'h0, 32'h13, 1'b0);
        check_eq("rst.fetch", fetch_cnt, 32'd0);
        check_eq("rst.flush", flush_cnt, 32'd0);

        // Sequential fetch
        rst = 1'b0;
        step();
        check_eq("f1.addr", imem_addr, 32'h3004);
        check_ifid("f1", 32'h3000, 32'h00A0_0093, 1'b1);
        check_eq("f1.op13", {25'd0, if_id_opcode}, 32'h13);
        check_eq("f1.fetch", fetch_cnt, 32'd1);
        step();
        check_eq("f2.addr", imem_addr, 32'h3008);
        check_ifid("f2", 32'h3004, mem_word(32'h3004), 1'b1);
        check_eq("f2.fetch", fetch_cnt, 32'd2);

        // Three-cycle stall at 0x3008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stl.addr", imem_addr, 32'h3008);
            check_ifid("stl", 32'h3004, mem_word(32'h3004), 1'b1);
            check_eq("stl.fetch", fetch_cnt, 32'd2);
        end
        stall = 1'b0;
        step();
        check_eq("res.addr", imem_addr, 32'h300C);
        check_ifid("res", 32'h3008, mem_word(32'h3008), 1'b1);
        check_eq("res.fetch", fetch_cnt, 32'd3);
        step();
        check_eq("f4.addr", imem_addr, 32'h3010);

        // Redirect with misaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h3103;
        step();
        check_eq("rd.addr", imem_addr, 32'h3100);
        check_ifid("rd", 32'h0, 32'h13, 1'b0);
        check_eq("rd.flush", flush_cnt, 32'd1);
        check_eq("rd.fetch", fetch_cnt, 32'd4);
        redirect = 1'b0;
        step();
        check_ifid("rdt", 32'h3100, 32'h40B5_0533, 1'b1);
        check_eq("rdt.addr", imem_addr, 32'h3104);
        check_eq("rdt.fetch", fetch_cnt, 32'd5);

        // Redirect beats stall, then a back-to-back redirect
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        step();
        check_eq("rs.addr", imem_addr, 32'h3200);
        check_eq("rs.valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rs.fetch", fetch_cnt, 32'd5);
        check_eq("rs.flush", flush_cnt, 32'd2);
        redirect_pc = 32'h3040;
        step();
        check_eq("rr.addr", imem_addr, 32'h3040);
        check_eq("rr.flush", flush_cnt, 32'd3);
        redirect = 1'b0;
        step();
        check_eq("rr.hold", imem_addr, 32'h3040);

        // Reset during stall
        rst = 1'b1;
        step();
        check_eq("rs2.addr", imem_addr, 32'h3000);
        check_ifid("rs2", 32'h0, 32'h13, 1'b0);
        check_eq("rs2.fetch", fetch_cnt, 32'd0);
        check_eq("rs2.flush", flush_cnt, 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        step();
        check_ifid("rs3", 32'h3000, 32'h00A0_0093, 1'b1);
        check_eq("rs3.fetch", fetch_cnt, 32'd1);

        // PC wraparound
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        check_eq("wr.addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wr.flush", flush_cnt, 32'd1);
        redirect = 1'b0;
        step();
        check_eq("wr2.addr", imem_addr, 32'h0);
        check_eq("wr2.pc", if_id_pc, 32'hFFFF_FFFC);
        check_eq("wr2.pc4", if_id_pc4, 32'h0);
        check_eq("wr2.ir", if_id_ir, mem_word(32'hFFFF_FFFC));
        check_eq("wr2.fetch", fetch_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core. It holds the program counter and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register, which feeds the decode stage and the main control decoder (opcode and bit 30). It also applies stall and redirect requests from hazard and branch/jump resolution, and keeps two debug counters for the PDU/debug port.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded by reset (text-segment base).
- NOP_INSN, 32'h0000_0013, bubble instruction inserted on flush/reset (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect  in  1  branch taken / jal / jalr resolved; overrides stall.
- redirect_pc  in  32  target PC when redirect=1.
- imem_addr  out  32  instruction-memory address; equals current PC (combinational).
- imem_data  in  32  instruction word, combinational read of imem_addr.
- if_id_pc  out  32  PC of instruction in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4 (link value for jal/jalr writeback).
- if_id_ir  out  32  instruction in IF/ID.
- if_id_opcode  out  7  if_id_ir[6:0], to control decoder.
- if_id_ir30  out  1  if_id_ir[30], to control decoder.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_cnt  out  32  number of valid instructions loaded into IF/ID.
- flush_cnt  out  32  number of accepted redirects.

## Operation
- State: pc (32), IF/ID {pc, pc4, ir, valid}, fetch_cnt, flush_cnt.
- Exactly one action per cycle, in priority order. rst is highest, then redirect, then stall, then normal.
  - RESET (rst=1):
    - pc <= PC_RESET.
    - IF/ID <= bubble: pc=0, pc4=0, ir=NOP_INSN, valid=0.
    - Both counters <= 0.
  - REDIRECT (redirect=1):
    - pc <= {redirect_pc[31:2], 2'b00}; the low two bits are always forced to zero.
    - IF/ID <= bubble.
    - flush_cnt += 1.
    - stall is ignored.
  - STALL (stall=1, redirect=0): pc, IF/ID and fetch_cnt all hold.
  - NORMAL:
    - pc <= pc + 4.
    - IF/ID <= {pc, pc+4, imem_data, 1}.
    - fetch_cnt += 1.
- Arithmetic:
  - All PC adds are 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
  - Counters wrap modulo 2^32.
- if_id_opcode and if_id_ir30 are slices of the registered if_id_ir; no extra latency.
- A bubble carries opcode 7'b0010011, so the decoder sees a harmless addi with rd=x0.

## Timing
- Fetch latency is 1 cycle: the word at imem_addr in cycle N appears on if_id_ir in cycle N+1.
- Reset:
  - First fetch address after rst deasserts is PC_RESET.
  - The first valid IF/ID appears one cycle later.
- Redirect:
  - Sampled at the edge where redirect=1; the target is fetched in the following cycle.
  - The instruction fetched during the redirect cycle is discarded: exactly one bubble.
  - Back-to-back redirects each produce a bubble and each increment flush_cnt.
- Stall: may last any number of cycles. imem_addr stays constant throughout, and IF/ID is unchanged bit-for-bit.
- Reset mid-stall or mid-redirect: rst wins in that cycle; all pending requests are lost.
- No combinational path exists from stall or redirect to any output.

## Test plan
- Reset release, no stall/redirect, imem returns 32'h00A00093 at 0x3000:
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - Cycle after first edge: if_id_pc=0x3000, if_id_pc4=0x3004, if_id_ir=32'h00A00093, if_id_opcode=7'h13, valid=1.
  - fetch_cnt increments by 1 per cycle.
- Stall for 3 cycles at pc=0x3008:
  - imem_addr holds 0x3008 for 3 cycles.
  - IF/ID holds the 0x3004 instruction.
  - fetch_cnt frozen.
  - Resumes at 0x300C.
- redirect=1, redirect_pc=0x3103 while pc=0x3010:
  - Next pc=0x3100.
  - IF/ID becomes bubble (ir=32'h00000013, valid=0).
  - flush_cnt=1.
  - The following cycle loads the 0x3100 instruction.
- stall=1 and redirect=1 together with redirect_pc=0x3200: redirect wins, pc=0x3200, bubble inserted, fetch_cnt unchanged.
- rst asserted during a stall with pc=0x3040: next cycle pc=0x3000, valid=0, both counters 0.
- Force pc=0xFFFF_FFFC via redirect, then a normal cycle: imem_addr=0x0000_0000, and if_id_pc4=0x0000_0000.
